// File: rtl/acc_mcpu.sv
// acc_mcpu: multicycle accumulator processor with handshaked I/O, host program load, carry flag and HALT state
module acc_mcpu #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5,
  parameter int RF_AW  = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [ADDR_W+3:0] prog_data,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              halted,
  output logic              busy
);
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, WAIT_IN, WAIT_OUT, HALT} state_t;
  localparam logic [3:0] OP_HALT = 4'd0, OP_LDA = 4'd1, OP_STA = 4'd2, OP_LDI = 4'd3,
                         OP_ADD = 4'd4, OP_SUB = 4'd5, OP_AND = 4'd6, OP_OR = 4'd7,
                         OP_NOT = 4'd8, OP_SHL = 4'd9, OP_SHR = 4'd10, OP_IN = 4'd11,
                         OP_OUT = 4'd12, OP_JMP = 4'd13, OP_JZ = 4'd14, OP_JP = 4'd15;
  state_t state, state_n;
  logic [ADDR_W+3:0] imem [2**ADDR_W];
  logic [DATA_W-1:0] rf [2**RF_AW];
  logic [ADDR_W+3:0] ir;
  logic [ADDR_W-1:0] pc, arg;
  logic [DATA_W-1:0] a, opnd;
  logic [3:0] op;
  logic c, take, stopped;
  assign op = ir[ADDR_W+3:ADDR_W];
  assign arg = ir[ADDR_W-1:0];
  assign stopped = state == IDLE || state == HALT;
  assign in_ready = state == WAIT_IN;
  assign halted = state == HALT;
  assign busy = !stopped;
  always_ff @(posedge clk)
    if (stopped && prog_we) imem[prog_addr] <= prog_data;
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE, HALT: state_n = start ? FETCH : state;
      FETCH:      state_n = DECODE;
      DECODE:     state_n = EXEC;
      EXEC:       state_n = op == OP_HALT ? HALT : op == OP_IN ? WAIT_IN : op == OP_OUT ? WAIT_OUT : FETCH;
      WAIT_IN:    state_n = in_valid ? FETCH : WAIT_IN;
      WAIT_OUT:   state_n = out_ready ? FETCH : WAIT_OUT;
      default:    state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (reset) begin
      pc <= '0;
      a <= '0;
      c <= 1'b0;
      ir <= '0;
      opnd <= '0;
      take <= 1'b0;
      out_data <= '0;
      out_valid <= 1'b0;
      for (int i = 0; i < 2**RF_AW; i++) rf[i] <= '0;
    end else
      case (state)
        IDLE, HALT: if (start) begin
          pc <= '0;
          a <= '0;
          c <= 1'b0;
        end
        FETCH: begin
          ir <= imem[pc];
          pc <= pc + ADDR_W'(1);
        end
        DECODE: begin
          opnd <= rf[ir[RF_AW-1:0]];
          take <= op == OP_JMP || (op == OP_JZ && a == '0) || (op == OP_JP && a != '0 && !a[DATA_W-1]);
        end
        EXEC: begin
          case (op)
            OP_LDA:  a <= opnd;
            OP_STA:  rf[ir[RF_AW-1:0]] <= a;
            OP_LDI:  a <= DATA_W'(arg);
            OP_ADD:  {c, a} <= {1'b0, a} + {1'b0, opnd};
            OP_SUB:  {c, a} <= {1'b0, a} - {1'b0, opnd};
            OP_AND:  a <= a & opnd;
            OP_OR:   a <= a | opnd;
            OP_NOT:  a <= ~a;
            OP_SHL:  {c, a} <= {a, 1'b0};
            OP_SHR:  {a, c} <= {1'b0, a};
            OP_OUT: begin
              out_data <= a;
              out_valid <= 1'b1;
            end
            default: ;
          endcase
          if (take) pc <= arg;
        end
        WAIT_IN:  if (in_valid) a <= in_data;
        WAIT_OUT: if (out_ready) out_valid <= 1'b0;
        default: ;
      endcase
endmodule

// File: tb/tb_acc_mcpu.sv
// tb_acc_mcpu: scenario tasks driving acc_mcpu with an output scoreboard checking every transfer
module tb_acc_mcpu;
  localparam int DW = 8, AW = 5, RW = 3;
  logic clk = 0, reset, start, prog_we, in_valid, out_ready;
  logic [AW-1:0] prog_addr;
  logic [AW+3:0] prog_data;
  logic [DW-1:0] in_data, out_data;
  logic in_ready, out_valid, halted, busy;
  int total = 0, bad = 0;
  logic [DW-1:0] exp_q[$];
  logic exp_c[$];
  logic [DW-1:0] in_q[$];
  logic [AW+3:0] prog[$];
  logic [DW-1:0] mon_d;
  logic mon_c;
  acc_mcpu #(.DATA_W(DW), .ADDR_W(AW), .RF_AW(RW)) dut (
    .clk(clk), .reset(reset), .start(start), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .halted(halted), .busy(busy)
  );
  always #5 clk = ~clk;
  // Every output transfer is matched against the next expected value and carry
  always @(negedge clk)
    if (!reset && out_valid && out_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_out got=%0d required=none", out_data);
      end else begin
        mon_d = exp_q.pop_front();
        mon_c = exp_c.pop_front();
        if (out_data !== mon_d || dut.c !== mon_c) begin
          bad++;
          $display("FAIL out_data got=%0d c=%b required=%0d c=%b", out_data, dut.c, mon_d, mon_c);
        end
      end
    end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  function automatic logic [AW+3:0] ins(input int op, input int arg);
    return {op[3:0], arg[AW-1:0]};
  endfunction
  task automatic expect_out(input int d, input int cy);
    exp_q.push_back(d[DW-1:0]);
    exp_c.push_back(cy[0]);
  endtask
  task automatic do_reset;
    reset = 1;
    tick;
    tick;
    reset = 0;
  endtask
  task automatic load;
    for (int i = 0; i < prog.size(); i++) begin
      prog_we = 1;
      prog_addr = i[AW-1:0];
      prog_data = prog[i];
      tick;
    end
    prog_we = 0;
  endtask
  task automatic wait_halt(input string nm, input int max);
    int n = 0;
    while (!halted && n < max) begin
      tick;
      n++;
    end
    total++;
    if (!halted) begin
      bad++;
      $display("FAIL %s_timeout halted=%b required=1", nm, halted);
    end
  endtask
  task automatic run(input string nm, input int max, output int cycles, output int vcyc);
    logic hs;
    start = 1;
    tick;
    start = 0;
    cycles = 0;
    vcyc = 0;
    while (!halted && cycles < max) begin
      in_valid = in_q.size() > 0;
      in_data = in_valid ? in_q[0] : '0;
      hs = in_valid && in_ready;
      tick;
      cycles++;
      if (hs) void'(in_q.pop_front());
      if (out_valid) vcyc++;
    end
    in_valid = 0;
    total++;
    if (!halted) begin
      bad++;
      $display("FAIL %s_timeout halted=%b required=1", nm, halted);
    end
  endtask
  task automatic check_drained(input string nm);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s_drain left=%0d required=0", nm, exp_q.size());
      exp_q.delete();
      exp_c.delete();
    end
  endtask
  task automatic test_reset;
    do_reset;
    total++;
    if ({out_data, out_valid, in_ready, halted, busy} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got=%h required=0", {out_data, out_valid, in_ready, halted, busy});
    end
    total++;
    if (dut.a !== '0 || dut.pc !== '0 || dut.c !== 1'b0) begin
      bad++;
      $display("FAIL reset_state a=%0d pc=%0d c=%b required=0", dut.a, dut.pc, dut.c);
    end
  endtask
  task automatic test_basic;
    int cyc, vc;
    out_ready = 1;
    prog = '{ins(3, 5), ins(2, 1), ins(3, 3), ins(4, 1), ins(12, 0), ins(0, 0)};
    load;
    expect_out(8, 0);
    run("basic", 100, cyc, vc);
    total++;
    if (cyc !== 19) begin
      bad++;
      $display("FAIL basic_latency got=%0d required=19", cyc);
    end
    total++;
    if (vc !== 1) begin
      bad++;
      $display("FAIL basic_valid_pulse got=%0d required=1", vc);
    end
    check_drained("basic");
  endtask
  task automatic test_arith;
    int cyc, vc;
    prog = '{ins(11, 0), ins(2, 1), ins(11, 0), ins(4, 1), ins(12, 0), ins(2, 3), ins(11, 0),
             ins(2, 2), ins(1, 3), ins(5, 2), ins(12, 0), ins(10, 0), ins(12, 0), ins(8, 0),
             ins(12, 0), ins(6, 1), ins(7, 2), ins(12, 0), ins(9, 0), ins(12, 0), ins(0, 0)};
    load;
    in_q = '{8'd100, 8'd200, 8'd45};
    expect_out(44, 1);
    expect_out(255, 1);
    expect_out(127, 1);
    expect_out(128, 1);
    expect_out(45, 1);
    expect_out(90, 0);
    run("arith", 300, cyc, vc);
    total++;
    if (in_q.size() != 0) begin
      bad++;
      $display("FAIL arith_inputs left=%0d required=0", in_q.size());
      in_q.delete();
    end
    check_drained("arith");
  endtask
  task automatic test_stall;
    int n, rc, vc;
    logic st;
    prog = '{ins(11, 0), ins(12, 0), ins(0, 0)};
    load;
    out_ready = 0;
    expect_out(8'h3C, 0);
    start = 1;
    tick;
    start = 0;
    n = 0;
    while (!in_ready && n < 20) begin
      tick;
      n++;
    end
    total++;
    if (n !== 3) begin
      bad++;
      $display("FAIL stall_in_latency got=%0d required=3", n);
    end
    rc = 0;
    for (int k = 0; k < 6; k++) begin
      in_valid = k == 5;
      in_data = k == 5 ? 8'h3C : 8'hA5;
      if (in_ready) rc++;
      tick;
    end
    in_valid = 0;
    total++;
    if (rc !== 6 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL stall_in_ready cycles=%0d now=%b required=6,0", rc, in_ready);
    end
    n = 0;
    while (!out_valid && n < 20) begin
      tick;
      n++;
    end
    vc = 0;
    st = 1;
    for (int k = 0; k < 5; k++) begin
      out_ready = k == 4;
      if (out_valid) vc++;
      if (out_data !== 8'h3C) st = 0;
      tick;
    end
    total++;
    if (vc !== 5 || st !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL stall_out valid_cycles=%0d stable=%b now=%b required=5,1,0", vc, st, out_valid);
    end
    out_ready = 1;
    wait_halt("stall", 50);
    check_drained("stall");
  endtask
  task automatic test_countdown;
    int cyc, vc;
    prog = '{ins(3, 1), ins(2, 1), ins(3, 3), ins(12, 0), ins(5, 1), ins(14, 7), ins(13, 3),
             ins(3, 16), ins(9, 0), ins(9, 0), ins(9, 0), ins(15, 17), ins(12, 0), ins(10, 0),
             ins(15, 17), ins(12, 0), ins(0, 0), ins(12, 0), ins(0, 0)};
    load;
    expect_out(3, 0);
    expect_out(2, 0);
    expect_out(1, 0);
    expect_out(128, 0);
    expect_out(64, 0);
    run("countdown", 400, cyc, vc);
    check_drained("countdown");
  endtask
  task automatic test_reset_wait_out;
    int n = 0;
    prog = '{ins(3, 7), ins(12, 0), ins(0, 0)};
    load;
    out_ready = 0;
    start = 1;
    tick;
    start = 0;
    while (!out_valid && n < 20) begin
      tick;
      n++;
    end
    tick;
    tick;
    total++;
    if (out_valid !== 1'b1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL rst_pre valid=%b busy=%b required=1,1", out_valid, busy);
    end
    reset = 1;
    tick;
    reset = 0;
    total++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || halted !== 1'b0 || dut.a !== '0) begin
      bad++;
      $display("FAIL rst_wait_out valid=%b busy=%b halted=%b a=%0d required=0,0,0,0", out_valid, busy, halted, dut.a);
    end
    out_ready = 1;
    tick;
    check_drained("rst_wait_out");
  endtask
  task automatic test_prog_we_busy;
    int cyc, vc;
    prog = '{ins(3, 6), ins(12, 0), ins(0, 0)};
    load;
    expect_out(6, 0);
    expect_out(6, 0);
    start = 1;
    tick;
    start = 0;
    prog_we = 1;
    prog_addr = '0;
    prog_data = ins(3, 9);
    tick;
    prog_we = 0;
    wait_halt("we_busy", 50);
    run("we_busy_rerun", 50, cyc, vc);
    check_drained("we_busy");
  endtask
  task automatic test_wrap;
    int cyc, vc;
    do_reset;
    prog = '{ins(1, 1), ins(12, 0), ins(14, 4), ins(0, 0), ins(3, 9), ins(2, 1)};
    for (int i = 6; i < 2**AW; i++) prog.push_back(ins(1, 1));
    load;
    expect_out(0, 0);
    expect_out(9, 0);
    run("wrap", 300, cyc, vc);
    total++;
    if (dut.pc !== AW'(4)) begin
      bad++;
      $display("FAIL wrap_pc got=%0d required=4", dut.pc);
    end
    check_drained("wrap");
  endtask
  initial begin
    reset = 1;
    start = 0;
    prog_we = 0;
    prog_addr = '0;
    prog_data = '0;
    in_valid = 0;
    in_data = '0;
    out_ready = 1;
    test_reset;
    test_basic;
    test_arith;
    test_stall;
    test_countdown;
    test_reset_wait_out;
    test_prog_we_busy;
    test_wrap;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
